uart_receive: RTL

UART receiver for 8-bit, LSB-first, one-stop-bit serial frames at a fixed bit period set by `CLKS_PER_BIT`. It is the counterpart of the UART transmit block and sits between the board RxD pin and the CPU-side I/O register file. It synchronizes `rxd` and validates the start bit at mid-bit. It samples data and stop bits at bit centres and holds one received byte for the consumer under a valid/ack handshake, with sticky framing and overrun flags.

---
 rtl/uart_receive.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_receive.sv
// UART receiver: 8N1 LSB-first frames, 2-flop input synchronizer, centre-of-bit
// sampling, one-byte holding register with valid/ack handshake and sticky flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky even-parity error flag.
module uart_receive #(
  parameter int CLKS_PER_BIT = 435
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       readAck,
  input  logic       errClear,
  output logic [7:0] dataOutput,
  output logic       dataValid,
  output logic       frameError,
  output logic       overrun,
  output logic       parityError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shift;
  logic          rxd_p0;
  logic          rxd_p1;
  logic          rxdS;
  logic          cntDone;

  assign rxdS    = rxd_p1;
  assign cntDone = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_p0     <= 1'b1;
      rxd_p1     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shift      <= '0;
      dataOutput <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError <= 1'b0;
`endif
    end else begin
      // stage p0/p1: metastability synchronizer
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;

      // clears come first so a flag set later in this block wins the same edge
      if (errClear) begin
        frameError <= 1'b0;
        overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parityError <= 1'b0;
`endif
      end
      if (readAck && dataValid)
        dataValid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxdS) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxdS) begin
              state  <= DATA;
              bitIdx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cntDone) begin
            cnt           <= '0;
            shift[bitIdx] <= rxdS;
            if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cntDone) begin
            cnt   <= '0;
            state <= STOP;
            if ((^shift) ^ rxdS)
              parityError <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cntDone) begin
            cnt <= '0;
            if (rxdS) begin
              dataOutput <= shift;
              dataValid  <= 1'b1;
              // an ack on this same edge consumes the old byte, so no overrun
              if (dataValid && !readAck)
                overrun <= 1'b1;
              state <= IDLE;
            end else begin
              frameError <= 1'b1;
              state      <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxdS)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parityError = 1'b0;
`endif

endmodule
